multi_cycle_cu: RTL and testbench

//  Multi-cycle successor to the single-cycle control unit. A Moore/Mealy FSM sequences each instruction

---
 rtl/multi_cycle_cu.sv | 210 +++++++++++++++++++++
 tb/tb_multi_cycle_cu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_cu.sv
// Multi-cycle control unit: sequences each instruction through IF/ID/EXE/MEM/WB and drives per-state strobes.
// Latency: strobes are combinational in state/Op/Func/flags; the state register advances on every CLK rise.
// Backpressure: none; memory wait is a fixed MEM_LAT cycles, and RST_n low masks every strobe immediately.
module multi_cycle_cu #(
   parameter int OP_W    = 6,
   parameter int FUNC_W  = 6,
   parameter int ALUOP_W = 3,
   parameter int MEM_LAT = 1
) (
   input  logic               CLK,
   input  logic               RST_n,
   input  logic [OP_W-1:0]    Op,
   input  logic [FUNC_W-1:0]  Func,
   input  logic               ZERO,
   input  logic               SIGN,
   output logic               PCWre,
   output logic               IRWre,
   output logic [1:0]         PCSel,
   output logic               ALUScrA,
   output logic               ALUScrB,
   output logic [ALUOP_W-1:0] ALUop,
   output logic               ExtSel,
   output logic               RegDst,
   output logic               DB,
   output logic               RegWr,
   output logic               nRD,
   output logic               nWR,
   output logic [2:0]         State
);

   // FSM state encodings (also exported for trace)
   localparam logic [2:0] S_IF  = 3'b000;
   localparam logic [2:0] S_ID  = 3'b001;
   localparam logic [2:0] S_EXE = 3'b010;
   localparam logic [2:0] S_MEM = 3'b011;
   localparam logic [2:0] S_WB  = 3'b100;
   localparam logic [2:0] S_HLT = 3'b111;

   // Opcodes
   localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
   localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
   localparam logic [OP_W-1:0] OP_BGTZ = OP_W'(6'b000111);
   localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
   localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_HALT = OP_W'(6'b111111);

   // R-format funct codes
   localparam logic [FUNC_W-1:0] F_SLL = FUNC_W'(6'b000000);
   localparam logic [FUNC_W-1:0] F_ADD = FUNC_W'(6'b100000);
   localparam logic [FUNC_W-1:0] F_SUB = FUNC_W'(6'b100010);
   localparam logic [FUNC_W-1:0] F_AND = FUNC_W'(6'b100100);
   localparam logic [FUNC_W-1:0] F_OR  = FUNC_W'(6'b100101);
   localparam logic [FUNC_W-1:0] F_SLT = FUNC_W'(6'b101010);

   // ALU operation codes
   localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b000);
   localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b001);
   localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(3'b010);
   localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b011);
   localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b100);
   localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b110);

   // PC source select
   localparam logic [1:0] PC_NEXT = 2'b00;
   localparam logic [1:0] PC_REL  = 2'b01;
   localparam logic [1:0] PC_ABS  = 2'b10;
   localparam logic [1:0] PC_HALT = 2'b11;

   // Memory wait counter: counts 0..MEM_LAT-1 and never wraps
   localparam int             CW       = $clog2(MEM_LAT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_LAT - 1);

   logic [2:0]    state;
   logic [2:0]    nxt;
   logic [CW-1:0] mem_cnt;

   logic is_r, r_known, is_branch, taken, is_lw, is_sw;

   assign State = state;

   // Instruction class decode, purely from the IR fields
   always_comb begin
      is_r      = (Op == OP_R);
      r_known   = is_r && ((Func == F_SLL) || (Func == F_ADD) || (Func == F_SUB) ||
                           (Func == F_AND) || (Func == F_OR)  || (Func == F_SLT));
      is_branch = (Op == OP_BEQ) || (Op == OP_BNE) || (Op == OP_BGTZ);
      is_lw     = (Op == OP_LW);
      is_sw     = (Op == OP_SW);
      taken     = ((Op == OP_BEQ)  &&  ZERO) ||
                  ((Op == OP_BNE)  && !ZERO) ||
                  ((Op == OP_BGTZ) && !SIGN && !ZERO);
   end

   // Datapath steering: depends on Op/Func only, so it is stable from ID through WB
   always_comb begin
      ALUScrA = is_r && (Func == F_SLL);
      ALUScrB = (Op == OP_ADDI) || (Op == OP_ORI) || is_lw || is_sw;
      ExtSel  = (Op != OP_ORI);
      RegDst  = !(is_lw || (Op == OP_ADDI) || (Op == OP_ORI));
      DB      = is_lw;
      ALUop   = ALU_ADD;
      if (is_branch) begin
         ALUop = ALU_SUB;
      end else if (Op == OP_ORI) begin
         ALUop = ALU_OR;
      end else if (is_r) begin
         case (Func)
            F_SUB:   ALUop = ALU_SUB;
            F_AND:   ALUop = ALU_AND;
            F_OR:    ALUop = ALU_OR;
            F_SLT:   ALUop = ALU_SLT;
            F_SLL:   ALUop = ALU_SLL;
            default: ALUop = ALU_ADD;
         endcase
      end
   end

   // Next-state and strobe generation; reset low masks all strobes in any state
   always_comb begin
      nxt   = S_IF;
      PCWre = 1'b0;
      IRWre = 1'b0;
      RegWr = 1'b0;
      nRD   = 1'b1;
      nWR   = 1'b1;
      PCSel = PC_NEXT;
      case (state)
         S_IF: begin
            IRWre = 1'b1;
            nxt   = S_ID;
         end
         S_ID: begin
            if (Op == OP_J) begin
               PCWre = 1'b1;
               PCSel = PC_ABS;
               nxt   = S_IF;
            end else if (Op == OP_HALT) begin
               nxt   = S_HLT;
            end else begin
               nxt   = S_EXE;
            end
         end
         S_EXE: begin
            if (is_branch) begin
               PCWre = 1'b1;
               PCSel = taken ? PC_REL : PC_NEXT;
               nxt   = S_IF;
            end else if (is_lw || is_sw) begin
               nxt   = S_MEM;
            end else if (r_known || (Op == OP_ADDI) || (Op == OP_ORI)) begin
               nxt   = S_WB;
            end else begin
               // Unrecognised instruction retires as a NOP
               PCWre = 1'b1;
               nxt   = S_IF;
            end
         end
         S_MEM: begin
            nRD = !is_lw;
            nWR = !is_sw;
            nxt = S_MEM;
            if (mem_cnt == CNT_LAST) begin
               if (is_lw) begin
                  nxt   = S_WB;
               end else begin
                  PCWre = 1'b1;
                  nxt   = S_IF;
               end
            end
         end
         S_WB: begin
            RegWr = 1'b1;
            PCWre = 1'b1;
            nxt   = S_IF;
         end
         S_HLT: begin
            PCSel = PC_HALT;
            nxt   = S_HLT;
         end
         default: nxt = S_IF;
      endcase
      if (!RST_n) begin
         PCWre = 1'b0;
         IRWre = 1'b0;
         RegWr = 1'b0;
         nRD   = 1'b1;
         nWR   = 1'b1;
      end
   end

   // State register and memory wait counter
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state   <= S_IF;
         mem_cnt <= '0;
      end else begin
         state <= nxt;
         if (state == S_EXE) begin
            mem_cnt <= '0;
         end else if ((state == S_MEM) && (mem_cnt != CNT_LAST)) begin
            mem_cnt <= mem_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_multi_cycle_cu.sv
// Directed bench for multi_cycle_cu: two instances (MEM_LAT=3 and MEM_LAT=1) share stimulus.
// Each step advances one clock and checks strobes #1 after the rising edge.
// Expected values are hand-derived encodings held as local constants.
module tb_multi_cycle_cu;

   localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                          OP_BNE = 6'b000101, OP_BGTZ = 6'b000111, OP_ORI = 6'b001101,
                          OP_LW = 6'b100011, OP_SW = 6'b101011, OP_HALT = 6'b111111,
                          OP_BAD = 6'b110011;
   localparam logic [5:0] F_ADD = 6'b100000, F_SLL = 6'b000000;
   localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3,
                          S_WB = 3'd4, S_HLT = 3'd7;
   localparam logic [2:0] A_ADD = 3'b000, A_SUB = 3'b001, A_SLL = 3'b010, A_OR = 3'b011;
   localparam logic [1:0] PC_NEXT = 2'b00, PC_REL = 2'b01, PC_ABS = 2'b10, PC_HALT = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op, func;
   logic       zero, sign;

   logic       pcwre_3, irwre_3, scra_3, scrb_3, ext_3, regdst_3, db_3, regwr_3, nrd_3, nwr_3;
   logic [1:0] pcsel_3;
   logic [2:0] aluop_3, state_3;
   logic       pcwre_1, irwre_1, scra_1, scrb_1, ext_1, regdst_1, db_1, regwr_1, nrd_1, nwr_1;
   logic [1:0] pcsel_1;
   logic [2:0] aluop_1, state_1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   multi_cycle_cu #(.OP_W(6), .FUNC_W(6), .ALUOP_W(3), .MEM_LAT(3)) u3 (
      .CLK(clk), .RST_n(rst_n), .Op(op), .Func(func), .ZERO(zero), .SIGN(sign),
      .PCWre(pcwre_3), .IRWre(irwre_3), .PCSel(pcsel_3), .ALUScrA(scra_3), .ALUScrB(scrb_3),
      .ALUop(aluop_3), .ExtSel(ext_3), .RegDst(regdst_3), .DB(db_3), .RegWr(regwr_3),
      .nRD(nrd_3), .nWR(nwr_3), .State(state_3));

   multi_cycle_cu #(.OP_W(6), .FUNC_W(6), .ALUOP_W(3), .MEM_LAT(1)) u1 (
      .CLK(clk), .RST_n(rst_n), .Op(op), .Func(func), .ZERO(zero), .SIGN(sign),
      .PCWre(pcwre_1), .IRWre(irwre_1), .PCSel(pcsel_1), .ALUScrA(scra_1), .ALUScrB(scrb_1),
      .ALUop(aluop_1), .ExtSel(ext_1), .RegDst(regdst_1), .DB(db_1), .RegWr(regwr_1),
      .nRD(nrd_1), .nWR(nwr_1), .State(state_1));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold reset for one edge, release it, leave both instances in IF
   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; op = OP_R; func = F_ADD; zero = 1'b0; sign = 1'b0;

      // Reset state: IF, but strobes masked while reset is low
      tick();
      chk("rst_state", 8'(state_3), 8'(S_IF));
      chk("rst_irwre", 8'(irwre_3), 8'd0);
      chk("rst_pcwre", 8'(pcwre_3), 8'd0);
      chk("rst_nrd_nwr", 8'({nrd_3, nwr_3}), 8'b11);
      rst_n = 1'b1; #1;

      // 1: ADD -> IF, ID, EXE, WB, IF
      chk("add_if_state", 8'(state_3), 8'(S_IF));
      chk("add_if_irwre", 8'(irwre_3), 8'd1);
      chk("add_if_pcwre", 8'(pcwre_3), 8'd0);
      tick();
      chk("add_id_state", 8'(state_3), 8'(S_ID));
      chk("add_id_strobes", 8'({pcwre_3, irwre_3, regwr_3}), 8'd0);
      tick();
      chk("add_exe_state", 8'(state_3), 8'(S_EXE));
      chk("add_exe_regwr", 8'(regwr_3), 8'd0);
      chk("add_exe_pcwre", 8'(pcwre_3), 8'd0);
      tick();
      chk("add_wb_state", 8'(state_3), 8'(S_WB));
      chk("add_wb_regwr", 8'(regwr_3), 8'd1);
      chk("add_wb_pcwre", 8'(pcwre_3), 8'd1);
      chk("add_wb_regdst", 8'(regdst_3), 8'd1);
      chk("add_wb_aluop", 8'(aluop_3), 8'(A_ADD));
      chk("add_wb_pcsel", 8'(pcsel_3), 8'(PC_NEXT));
      tick();
      chk("add_next_if", 8'(state_3), 8'(S_IF));

      // SLL decode: shift amount source, SLL ALU code
      func = F_SLL; #1;
      chk("sll_scra", 8'(scra_3), 8'd1);
      chk("sll_aluop", 8'(aluop_3), 8'(A_SLL));

      // 2: LW with MEM_LAT=3 -> 7 cycles
      op = OP_LW; func = 6'd0;
      do_reset();
      tick(); tick();
      chk("lw_exe_state", 8'(state_3), 8'(S_EXE));
      chk("lw_exe_nrd", 8'(nrd_3), 8'd1);
      chk("lw_scrb", 8'(scrb_3), 8'd1);
      chk("lw_regdst", 8'(regdst_3), 8'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("lw_mem%0d_state", i), 8'(state_3), 8'(S_MEM));
         chk($sformatf("lw_mem%0d_nrd", i), 8'(nrd_3), 8'd0);
         chk($sformatf("lw_mem%0d_pcwre_regwr", i), 8'({pcwre_3, regwr_3}), 8'd0);
      end
      tick();
      chk("lw_wb_state", 8'(state_3), 8'(S_WB));
      chk("lw_wb_nrd", 8'(nrd_3), 8'd1);
      chk("lw_wb_db", 8'(db_3), 8'd1);
      chk("lw_wb_regwr", 8'(regwr_3), 8'd1);
      tick();
      chk("lw_next_if", 8'(state_3), 8'(S_IF));

      // 3: branches
      op = OP_BEQ; zero = 1'b1; sign = 1'b0;
      do_reset(); tick(); tick();
      chk("beq_exe_state", 8'(state_3), 8'(S_EXE));
      chk("beq_taken_pcsel", 8'(pcsel_3), 8'(PC_REL));
      chk("beq_pcwre", 8'(pcwre_3), 8'd1);
      chk("beq_aluop", 8'(aluop_3), 8'(A_SUB));
      tick();
      chk("beq_next_if", 8'(state_3), 8'(S_IF));

      op = OP_BNE; zero = 1'b1;
      do_reset(); tick(); tick();
      chk("bne_z1_pcsel", 8'(pcsel_3), 8'(PC_NEXT));
      chk("bne_z1_pcwre", 8'(pcwre_3), 8'd1);
      zero = 1'b0; #1;
      chk("bne_z0_pcsel", 8'(pcsel_3), 8'(PC_REL));

      op = OP_BGTZ; zero = 1'b0; sign = 1'b0;
      do_reset(); tick(); tick();
      chk("bgtz_pos_pcsel", 8'(pcsel_3), 8'(PC_REL));
      sign = 1'b1; #1;
      chk("bgtz_neg_pcsel", 8'(pcsel_3), 8'(PC_NEXT));
      sign = 1'b0; zero = 1'b1; #1;
      chk("bgtz_zero_pcsel", 8'(pcsel_3), 8'(PC_NEXT));
      zero = 1'b0;

      // 4: SW with MEM_LAT=1 on the second instance
      op = OP_SW;
      do_reset();
      chk("sw_if_regwr", 8'(regwr_1), 8'd0);
      tick();
      chk("sw_id_regwr", 8'(regwr_1), 8'd0);
      tick();
      chk("sw_exe_regwr", 8'(regwr_1), 8'd0);
      chk("sw_exe_nwr", 8'(nwr_1), 8'd1);
      tick();
      chk("sw_mem_state", 8'(state_1), 8'(S_MEM));
      chk("sw_mem_nwr", 8'(nwr_1), 8'd0);
      chk("sw_mem_nrd", 8'(nrd_1), 8'd1);
      chk("sw_mem_pcwre", 8'(pcwre_1), 8'd1);
      chk("sw_mem_pcsel", 8'(pcsel_1), 8'(PC_NEXT));
      chk("sw_mem_regwr", 8'(regwr_1), 8'd0);
      tick();
      chk("sw_next_if", 8'(state_1), 8'(S_IF));
      chk("sw_next_nwr", 8'(nwr_1), 8'd1);

      // J: two cycles, absolute jump in ID
      op = OP_J;
      do_reset(); tick();
      chk("j_id_pcwre", 8'(pcwre_3), 8'd1);
      chk("j_id_pcsel", 8'(pcsel_3), 8'(PC_ABS));
      tick();
      chk("j_next_if", 8'(state_3), 8'(S_IF));

      // ORI: zero extension, immediate operand, rt destination
      op = OP_ORI; #1;
      chk("ori_ext", 8'(ext_3), 8'd0);
      chk("ori_aluop", 8'(aluop_3), 8'(A_OR));
      chk("ori_scrb_regdst", 8'({scrb_3, regdst_3}), 8'b10);

      // Unknown opcode retires as NOP in EXE
      op = OP_BAD;
      do_reset(); tick(); tick();
      chk("nop_exe_pcwre", 8'(pcwre_3), 8'd1);
      chk("nop_exe_regwr", 8'(regwr_3), 8'd0);
      tick();
      chk("nop_next_if", 8'(state_3), 8'(S_IF));

      // 5: HALT persists until reset
      op = OP_HALT;
      do_reset(); tick(); tick();
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("hlt%0d_state", i), 8'(state_3), 8'(S_HLT));
         chk($sformatf("hlt%0d_pcwre", i), 8'(pcwre_3), 8'd0);
         chk($sformatf("hlt%0d_pcsel", i), 8'(pcsel_3), 8'(PC_HALT));
         tick();
      end
      do_reset();
      chk("hlt_reset_if", 8'(state_3), 8'(S_IF));

      // 6: reset asserted during MEM of LW aborts it
      op = OP_LW;
      do_reset(); tick(); tick(); tick();
      chk("abort_mem_state", 8'(state_3), 8'(S_MEM));
      chk("abort_mem_nrd", 8'(nrd_3), 8'd0);
      rst_n = 1'b0; #1;
      chk("abort_nrd_masked", 8'(nrd_3), 8'd1);
      chk("abort_regwr", 8'(regwr_3), 8'd0);
      tick();
      chk("abort_state_if", 8'(state_3), 8'(S_IF));
      chk("abort_no_wb_regwr", 8'(regwr_3), 8'd0);
      rst_n = 1'b1; #1;
      chk("abort_restart_irwre", 8'(irwre_3), 8'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
